rf_am_modulator: RTL

//   Downstream stage of the video top: consumes the 1-bit video and csync from the PAL sync

---
 rtl/rf_am_modulator.sv | 111 +++++++++++
 1 files changed

// File: rtl/rf_am_modulator.sv
// Negative-AM RF output stage: maps csync/video to carrier amplitude codes, renders the
// amplitude with a first-order sigma-delta and gates a square-wave NCO carrier with it.
module rf_am_modulator #(
    parameter int unsigned PHASE_W     = 16,
    parameter int unsigned PHASE_INC   = 16384,
    parameter logic [7:0]  LVL_SYNC    = 8'd255,
    parameter logic [7:0]  LVL_BLACK   = 8'd192,
    parameter logic [7:0]  LVL_WHITE   = 8'd32,
    parameter int unsigned WDOG_CYCLES = 2048
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_video,
    input  logic       i_csync,
    input  logic       i_enable,
    output logic [7:0] o_level,
    output logic       o_no_sync,
    output logic       o_rf_out
);

    localparam int unsigned CNT_W = $clog2(WDOG_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WDOG_CYCLES);
    localparam logic [PHASE_W-1:0] INC = PHASE_W'(PHASE_INC);

    logic               r_video;
    logic               r_csync;
    logic               r_csyncD;
    logic [CNT_W-1:0]   r_wdogCnt;
    logic               r_noSync;
    logic [7:0]         r_level;
    logic [7:0]         r_acc;
    logic               r_pdm;
    logic [PHASE_W-1:0] r_phase;
    logic               r_rfOut;

    logic               w_edge;
    logic               w_cntSat;
    logic [8:0]         w_sum;
    logic               w_carrier;

    assign w_edge    = (r_csync != r_csyncD);
    assign w_cntSat  = (r_wdogCnt == CNT_MAX);
    assign w_sum     = {1'b0, r_acc} + {1'b0, r_level};
    assign w_carrier = r_phase[PHASE_W-1];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_video  <= 1'b0;
            r_csync  <= 1'b0;
            r_csyncD <= 1'b0;
        end else begin
            r_video  <= i_video;
            r_csync  <= i_csync;
            r_csyncD <= r_csync;
        end
    end

    // An edge always wins over saturation, so no_sync drops the cycle after sync returns.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wdogCnt <= '0;
            r_noSync  <= 1'b0;
        end else begin
            if (w_edge) begin
                r_wdogCnt <= '0;
            end else if (!w_cntSat) begin
                r_wdogCnt <= r_wdogCnt + CNT_W'(1);
            end
            r_noSync <= w_cntSat && !w_edge;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_level <= 8'd0;
        end else if (r_noSync) begin
            r_level <= LVL_BLACK;
        end else if (!r_csync) begin
            r_level <= LVL_SYNC;
        end else if (r_video) begin
            r_level <= LVL_WHITE;
        end else begin
            r_level <= LVL_BLACK;
        end
    end

    // Disabling clears the carrier phase and modulator so a re-enable starts deterministically.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_acc   <= 8'd0;
            r_pdm   <= 1'b0;
            r_phase <= '0;
            r_rfOut <= 1'b0;
        end else if (!i_enable) begin
            r_acc   <= 8'd0;
            r_pdm   <= 1'b0;
            r_phase <= '0;
            r_rfOut <= 1'b0;
        end else begin
            r_acc   <= w_sum[7:0];
            r_pdm   <= w_sum[8];
            r_phase <= r_phase + INC;
            r_rfOut <= w_carrier & r_pdm;
        end
    end

    assign o_level   = r_level;
    assign o_no_sync = r_noSync;
    assign o_rf_out  = r_rfOut;

endmodule
